// File: rtl/subleq_mem_arbiter.sv
// Round-robin arbiter sharing the single sync-read RAM between the SUBLEQ core and the UART monitor, with CPU halt handshake.
// Latency: gnt + mem_en one cycle after the request is seen idle, rvalid one cycle later; backpressure: req is held until gnt, one access per 3 cycles.
module subleq_mem_arbiter #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          mon_req,
    input  logic          mon_we,
    input  logic [AW-1:0] mon_addr,
    input  logic [DW-1:0] mon_wdata,
    output logic          mon_gnt,
    output logic          mon_rvalid,
    output logic [DW-1:0] mon_rdata,
    input  logic          halt_req,
    output logic          halt_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

    state_t        state, state_nxt;
    logic          owner_cpu, owner_nxt;
    logic          last_cpu, last_nxt;
    logic          op_we;
    logic          grant, pick_cpu, ack_nxt;
    logic          cpu_req_eff;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // A halted CPU simply stops competing; the monitor keeps being served.
    assign cpu_req_eff = cpu_req & ~halt_req;

    assign sel_we    = pick_cpu ? cpu_we    : mon_we;
    assign sel_addr  = pick_cpu ? cpu_addr  : mon_addr;
    assign sel_wdata = pick_cpu ? cpu_wdata : mon_wdata;

    always_comb begin
        state_nxt = state;
        owner_nxt = owner_cpu;
        last_nxt  = last_cpu;
        grant     = 1'b0;
        pick_cpu  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_req_eff || mon_req) begin
                    grant     = 1'b1;
                    pick_cpu  = cpu_req_eff & (~mon_req | ~last_cpu);
                    owner_nxt = pick_cpu;
                    last_nxt  = pick_cpu;
                    state_nxt = ACC;
                end
            end
            ACC:     state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Ack only once no CPU access will be in ACC or RESP next cycle.
        ack_nxt = halt_req & ~(((state_nxt == ACC) || (state_nxt == RESP)) & owner_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner_cpu <= 1'b0;
            last_cpu  <= 1'b0;
            op_we     <= 1'b0;
            halt_ack  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nxt;
            owner_cpu <= owner_nxt;
            last_cpu  <= last_nxt;
            halt_ack  <= ack_nxt;
            mem_en    <= grant;
            mem_we    <= grant & sel_we;
            if (grant) begin
                op_we     <= sel_we;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
        end
    end

    assign cpu_gnt    = (state == ACC) & owner_cpu;
    assign mon_gnt    = (state == ACC) & ~owner_cpu;
    assign cpu_rvalid = (state == RESP) & owner_cpu & ~op_we;
    assign mon_rvalid = (state == RESP) & ~owner_cpu & ~op_we;
    assign cpu_rdata  = mem_rdata;
    assign mon_rdata  = mem_rdata;

endmodule
